writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// Writeback stage: retires ALU/load results to the register file and
// runs the two-beat dcache store handshake (address, data, completion).
//
// Ports:
//   clk, reset                   stage clock, synchronous active-high reset
//   opcodeValidIn, canWbIn       upstream valid / memory stage finished
//   currentRipIn                 RIP of the incoming instruction
//   destReg*In                   destination code, write enable, ALU value
//   useMemoryDataIn/memoryDataIn load data select and value
//   isMemoryAccessDestIn         instruction stores to memory
//   memoryAddressDestIn          store address
//   dcReqcyc/dcReq/dcReqtag      dcache request beat valid/payload/tag
//   dcReqack                     dcache accepted current beat
//   dcRespcyc/dcRespack          store completion and its acknowledge
//   regWrEn/regWrAddr/regWrData  register-file write port
//   wbStallOut                   upstream must hold
//   retireOut/retireRipOut       retire pulse and its RIP
module writeback #(
    parameter int TAG_WIDTH = 13,
    parameter logic [TAG_WIDTH-1:0] WRITE_TAG =
        TAG_WIDTH'(13'h1000)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 opcodeValidIn,
    input  logic                 canWbIn,
    input  logic [63:0]          currentRipIn,
    input  logic [3:0]           destRegIn,
    input  logic                 destRegWriteIn,
    input  logic [63:0]          destRegValueIn,
    input  logic                 useMemoryDataIn,
    input  logic [63:0]          memoryDataIn,
    input  logic                 isMemoryAccessDestIn,
    input  logic [63:0]          memoryAddressDestIn,
    output logic                 dcReqcyc,
    output logic [63:0]          dcReq,
    output logic [TAG_WIDTH-1:0] dcReqtag,
    input  logic                 dcReqack,
    input  logic                 dcRespcyc,
    output logic                 dcRespack,
    output logic                 regWrEn,
    output logic [3:0]           regWrAddr,
    output logic [63:0]          regWrData,
    output logic                 wbStallOut,
    output logic                 retireOut,
    output logic [63:0]          retireRipOut
);

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_ADDR,
        WB_DATA,
        WB_RESP
    } wbState_t;

    // Instruction fields held while a store is in flight.
    typedef struct packed {
        logic [63:0] rip;
        logic [3:0]  dest;
        logic        destWrite;
        logic [63:0] data;
    } wbLatch_t;

    wbState_t    state;
    wbLatch_t    held;
    logic        accept;
    logic [63:0] selData;

    assign accept = (state == WB_IDLE) && opcodeValidIn
                    && canWbIn && !reset;

    assign selData = useMemoryDataIn ? memoryDataIn
                                     : destRegValueIn;

    // A store stalls upstream from its accept cycle so the
    // following instruction waits for the handshake to finish.
    assign wbStallOut = !reset && ((state != WB_IDLE)
                        || (accept && isMemoryAccessDestIn));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WB_IDLE;
            held         <= '0;
            dcReqcyc     <= 1'b0;
            dcReq        <= '0;
            dcReqtag     <= '0;
            dcRespack    <= 1'b0;
            regWrEn      <= 1'b0;
            regWrAddr    <= '0;
            regWrData    <= '0;
            retireOut    <= 1'b0;
            retireRipOut <= '0;
        end else begin
            regWrEn   <= 1'b0;
            retireOut <= 1'b0;
            dcRespack <= 1'b0;

            unique case (state)
                WB_IDLE: begin
                    if (accept) begin
                        held.rip       <= currentRipIn;
                        held.dest      <= destRegIn;
                        held.destWrite <= destRegWriteIn;
                        held.data      <= selData;
                        if (isMemoryAccessDestIn) begin
                            state    <= WB_ADDR;
                            dcReqcyc <= 1'b1;
                            dcReq    <= memoryAddressDestIn;
                            dcReqtag <= WRITE_TAG;
                        end else begin
                            regWrEn      <= destRegWriteIn;
                            regWrAddr    <= destRegIn;
                            regWrData    <= selData;
                            retireOut    <= 1'b1;
                            retireRipOut <= currentRipIn;
                        end
                    end
                end

                WB_ADDR: begin
                    if (dcReqack) begin
                        state <= WB_DATA;
                        dcReq <= held.data;
                    end
                end

                WB_DATA: begin
                    if (dcReqack) begin
                        state    <= WB_RESP;
                        dcReqcyc <= 1'b0;
                    end
                end

                WB_RESP: begin
                    if (dcRespcyc) begin
                        state        <= WB_IDLE;
                        dcRespack    <= 1'b1;
                        regWrEn      <= held.destWrite;
                        regWrAddr    <= held.dest;
                        regWrData    <= held.data;
                        retireOut    <= 1'b1;
                        retireRipOut <= held.rip;
                    end
                end
            endcase
        end
    end

endmodule
